al_axil_bridge: RTL

//  Parametrised AL-to-AXI-Lite master bridge: converts word-addressed AL read/write requests into AXI-Lite

---
 rtl/al_axil_pkg.sv | 25 ++
 rtl/al_sync_fifo.sv | 54 +++++
 rtl/al_axil_bridge.sv | 265 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/al_axil_pkg.sv
// Package for the AL-to-AXI-Lite bridge.
// Holds the AXI response codes, the channel state encoding and the helper
// that derives the word-address shift from the data width.
package al_axil_pkg;

  typedef logic [1:0] resp_t;

  localparam resp_t RESP_OKAY   = 2'b00;
  localparam resp_t RESP_SLVERR = 2'b10;
  localparam resp_t RESP_DECERR = 2'b11;

  // IDLE: nothing outstanding, BUSY: awaiting responses,
  // LOCKED: watchdog expired, direction closed until reset.
  typedef enum logic [1:0] {
    CH_IDLE   = 2'd0,
    CH_BUSY   = 2'd1,
    CH_LOCKED = 2'd2
  } chan_state_t;

  // Number of byte-address bits below the AL word address.
  function automatic int unsigned al_lsb(input int unsigned data_width);
    return $clog2(data_width / 8);
  endfunction

endpackage

// File: rtl/al_sync_fifo.sv
// First-word-fall-through synchronous FIFO used for the bridge's response
// queues. rd_data always shows the oldest entry while empty is low.
// Ports:
//   clk, rst        clock, synchronous active-high reset (empties the FIFO)
//   wr_en, wr_data  push (ignored when full)
//   rd_en, rd_data  pop (ignored when empty) / head entry
//   empty           no entries stored
//   count           number of stored entries, 0..DEPTH
module al_sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       wr_en,
  input  logic [WIDTH-1:0]           wr_data,
  input  logic                       rd_en,
  output logic [WIDTH-1:0]           rd_data,
  output logic                       empty,
  output logic [$clog2(DEPTH):0]     count
);

  localparam int AW   = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNTW = $clog2(DEPTH) + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             do_wr;
  logic             do_rd;

  assign empty   = (count == '0);
  assign do_wr   = wr_en && (count != CNTW'(DEPTH));
  assign do_rd   = rd_en && !empty;
  assign rd_data = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (do_wr) mem[wr_ptr] <= wr_data;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_wr) wr_ptr <= (wr_ptr == AW'(DEPTH - 1)) ? '0 : wr_ptr + AW'(1);
      if (do_rd) rd_ptr <= (rd_ptr == AW'(DEPTH - 1)) ? '0 : rd_ptr + AW'(1);
      if (do_wr && !do_rd)      count <= count + CNTW'(1);
      else if (!do_wr && do_rd) count <= count - CNTW'(1);
    end
  end

endmodule

// File: rtl/al_axil_bridge.sv
// AL-to-AXI-Lite master bridge. Converts word-addressed AL read/write
// requests into AXI-Lite transactions with up to MAX_OUT outstanding per
// direction; responses come back on AL in issue order through a FWFT FIFO.
// Read and write paths are fully independent.
// Optional feature: define AL_AXIL_TIMEOUT_EN to enable a per-direction
// response watchdog that answers all outstanding requests with SLVERR and
// locks the direction until reset.
// Ports:
//   clk, rst                  clock, synchronous active-high reset
//   s_axi_aw*/w*/b*/ar*/r*    AXI-Lite master interface (prot tied 0)
//   m_al_waddr/wdata/wstrb/wvalid/wready   AL write request
//   m_al_bresp/bvalid/bready               AL write response
//   m_al_araddr/arvalid/arready            AL read request
//   m_al_rdata/rresp/rvalid/rready         AL read data
//   m_al_timeout              sticky {rd,wr} watchdog flags
module al_axil_bridge
  import al_axil_pkg::*;
#(
  parameter int ADDR_WIDTH  = 32,
  parameter int DATA_WIDTH  = 32,
  parameter int MAX_OUT     = 4,
  parameter int TIMEOUT_CYC = 1024
) (
  input  logic                                     clk,
  input  logic                                     rst,
  output logic [ADDR_WIDTH-1:0]                    s_axi_awaddr,
  output logic [2:0]                               s_axi_awprot,
  output logic                                     s_axi_awvalid,
  input  logic                                     s_axi_awready,
  output logic [DATA_WIDTH-1:0]                    s_axi_wdata,
  output logic [DATA_WIDTH/8-1:0]                  s_axi_wstrb,
  output logic                                     s_axi_wvalid,
  input  logic                                     s_axi_wready,
  input  logic [1:0]                               s_axi_bresp,
  input  logic                                     s_axi_bvalid,
  output logic                                     s_axi_bready,
  output logic [ADDR_WIDTH-1:0]                    s_axi_araddr,
  output logic [2:0]                               s_axi_arprot,
  output logic                                     s_axi_arvalid,
  input  logic                                     s_axi_arready,
  input  logic [DATA_WIDTH-1:0]                    s_axi_rdata,
  input  logic [1:0]                               s_axi_rresp,
  input  logic                                     s_axi_rvalid,
  output logic                                     s_axi_rready,
  input  logic [ADDR_WIDTH-al_lsb(DATA_WIDTH)-1:0] m_al_waddr,
  input  logic [DATA_WIDTH-1:0]                    m_al_wdata,
  input  logic [DATA_WIDTH/8-1:0]                  m_al_wstrb,
  input  logic                                     m_al_wvalid,
  output logic                                     m_al_wready,
  output logic [1:0]                               m_al_bresp,
  output logic                                     m_al_bvalid,
  input  logic                                     m_al_bready,
  input  logic [ADDR_WIDTH-al_lsb(DATA_WIDTH)-1:0] m_al_araddr,
  input  logic                                     m_al_arvalid,
  output logic                                     m_al_arready,
  output logic [DATA_WIDTH-1:0]                    m_al_rdata,
  output logic [1:0]                               m_al_rresp,
  output logic                                     m_al_rvalid,
  input  logic                                     m_al_rready,
  output logic [1:0]                               m_al_timeout
);

  localparam int STRB_W = DATA_WIDTH / 8;
  localparam int LSB    = al_lsb(DATA_WIDTH);
  localparam int CW     = $clog2(MAX_OUT) + 1;
  localparam logic [CW:0] MAX_CNT = (CW + 1)'(MAX_OUT);

  // Response FIFOs always have room because credits count both in-flight
  // requests and queued responses; the slave is never back-pressured.
  assign s_axi_bready = 1'b1;
  assign s_axi_rready = 1'b1;
  assign s_axi_awprot = 3'b000;
  assign s_axi_arprot = 3'b000;

  // ------------------------------------------------------------ write path
  logic                  aw_pend, w_pend;
  logic [ADDR_WIDTH-1:0] awaddr_q;
  logic [DATA_WIDTH-1:0] wdata_q;
  logic [STRB_W-1:0]     wstrb_q;
  logic [CW-1:0]         wr_out, wr_out_nxt, bcnt;
  chan_state_t           wr_state;
  logic                  wr_accept, wr_credit, wr_locked, wr_dec;
  logic                  b_hs, b_push, bfifo_empty;
  resp_t                 b_push_data, bfifo_q;

  assign b_hs        = s_axi_bvalid;
  assign wr_locked   = (wr_state == CH_LOCKED);
  assign wr_credit   = ({1'b0, wr_out} + {1'b0, bcnt}) < MAX_CNT;
  assign m_al_wready = !rst && !aw_pend && !w_pend && wr_credit && !wr_locked;
  assign wr_accept   = m_al_wvalid && m_al_wready;

`ifdef AL_AXIL_TIMEOUT_EN
  logic        wr_drain, wr_fire, wr_to;
  logic [31:0] wr_tmr;
  // Once locked, each cycle retires one outstanding write as SLVERR and
  // late slave responses are swallowed.
  assign wr_drain    = wr_locked && (wr_out != '0);
  assign wr_fire     = (wr_state == CH_BUSY) && !b_hs && (wr_tmr == 32'(TIMEOUT_CYC - 1));
  assign wr_dec      = wr_locked ? wr_drain : b_hs;
  assign b_push      = wr_drain || (b_hs && !wr_locked);
  assign b_push_data = wr_drain ? RESP_SLVERR : s_axi_bresp;
`else
  assign wr_dec      = b_hs;
  assign b_push      = b_hs;
  assign b_push_data = s_axi_bresp;
`endif

  always_comb begin
    wr_out_nxt = wr_out;
    if (wr_accept && !wr_dec)      wr_out_nxt = wr_out + CW'(1);
    else if (!wr_accept && wr_dec) wr_out_nxt = wr_out - CW'(1);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      aw_pend  <= 1'b0;
      w_pend   <= 1'b0;
      awaddr_q <= '0;
      wdata_q  <= '0;
      wstrb_q  <= '0;
      wr_out   <= '0;
      wr_state <= CH_IDLE;
`ifdef AL_AXIL_TIMEOUT_EN
      wr_tmr   <= '0;
      wr_to    <= 1'b0;
`endif
    end else begin
      wr_out <= wr_out_nxt;
      if (wr_accept) begin
        aw_pend  <= 1'b1;
        w_pend   <= 1'b1;
        awaddr_q <= {m_al_waddr, {LSB{1'b0}}};
        wdata_q  <= m_al_wdata;
        wstrb_q  <= m_al_wstrb;
      end else begin
        if (s_axi_awready) aw_pend <= 1'b0;
        if (s_axi_wready)  w_pend  <= 1'b0;
      end
      case (wr_state)
        CH_IDLE, CH_BUSY: wr_state <= (wr_out_nxt != '0) ? CH_BUSY : CH_IDLE;
        default:          wr_state <= CH_LOCKED;
      endcase
`ifdef AL_AXIL_TIMEOUT_EN
      if (wr_state != CH_BUSY || b_hs) wr_tmr <= '0;
      else                             wr_tmr <= wr_tmr + 32'd1;
      if (wr_fire) begin
        wr_state <= CH_LOCKED;
        wr_to    <= 1'b1;
        aw_pend  <= 1'b0;
        w_pend   <= 1'b0;
      end
`endif
    end
  end

  assign s_axi_awaddr  = awaddr_q;
  assign s_axi_awvalid = aw_pend;
  assign s_axi_wdata   = wdata_q;
  assign s_axi_wstrb   = wstrb_q;
  assign s_axi_wvalid  = w_pend;

  al_sync_fifo #(.WIDTH(2), .DEPTH(MAX_OUT)) u_bfifo (
    .clk     (clk),
    .rst     (rst),
    .wr_en   (b_push),
    .wr_data (b_push_data),
    .rd_en   (m_al_bready),
    .rd_data (bfifo_q),
    .empty   (bfifo_empty),
    .count   (bcnt)
  );

  assign m_al_bvalid = !bfifo_empty;
  assign m_al_bresp  = bfifo_q;

  // ------------------------------------------------------------- read path
  logic                    ar_pend;
  logic [ADDR_WIDTH-1:0]   araddr_q;
  logic [CW-1:0]           rd_out, rd_out_nxt, rcnt;
  chan_state_t             rd_state;
  logic                    rd_accept, rd_credit, rd_locked, rd_dec;
  logic                    r_hs, r_push, rfifo_empty;
  logic [DATA_WIDTH+1:0]   r_push_data, rfifo_q;

  assign r_hs         = s_axi_rvalid;
  assign rd_locked    = (rd_state == CH_LOCKED);
  assign rd_credit    = ({1'b0, rd_out} + {1'b0, rcnt}) < MAX_CNT;
  assign m_al_arready = !rst && !ar_pend && rd_credit && !rd_locked;
  assign rd_accept    = m_al_arvalid && m_al_arready;

`ifdef AL_AXIL_TIMEOUT_EN
  logic        rd_drain, rd_fire, rd_to;
  logic [31:0] rd_tmr;
  assign rd_drain    = rd_locked && (rd_out != '0);
  assign rd_fire     = (rd_state == CH_BUSY) && !r_hs && (rd_tmr == 32'(TIMEOUT_CYC - 1));
  assign rd_dec      = rd_locked ? rd_drain : r_hs;
  assign r_push      = rd_drain || (r_hs && !rd_locked);
  assign r_push_data = rd_drain ? {RESP_SLVERR, {DATA_WIDTH{1'b0}}} : {s_axi_rresp, s_axi_rdata};
  assign m_al_timeout = {rd_to, wr_to};
`else
  assign rd_dec       = r_hs;
  assign r_push       = r_hs;
  assign r_push_data  = {s_axi_rresp, s_axi_rdata};
  assign m_al_timeout = 2'b00;
`endif

  always_comb begin
    rd_out_nxt = rd_out;
    if (rd_accept && !rd_dec)      rd_out_nxt = rd_out + CW'(1);
    else if (!rd_accept && rd_dec) rd_out_nxt = rd_out - CW'(1);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ar_pend  <= 1'b0;
      araddr_q <= '0;
      rd_out   <= '0;
      rd_state <= CH_IDLE;
`ifdef AL_AXIL_TIMEOUT_EN
      rd_tmr   <= '0;
      rd_to    <= 1'b0;
`endif
    end else begin
      rd_out <= rd_out_nxt;
      if (rd_accept) begin
        ar_pend  <= 1'b1;
        araddr_q <= {m_al_araddr, {LSB{1'b0}}};
      end else if (s_axi_arready) begin
        ar_pend  <= 1'b0;
      end
      case (rd_state)
        CH_IDLE, CH_BUSY: rd_state <= (rd_out_nxt != '0) ? CH_BUSY : CH_IDLE;
        default:          rd_state <= CH_LOCKED;
      endcase
`ifdef AL_AXIL_TIMEOUT_EN
      if (rd_state != CH_BUSY || r_hs) rd_tmr <= '0;
      else                             rd_tmr <= rd_tmr + 32'd1;
      if (rd_fire) begin
        rd_state <= CH_LOCKED;
        rd_to    <= 1'b1;
        ar_pend  <= 1'b0;
      end
`endif
    end
  end

  assign s_axi_araddr  = araddr_q;
  assign s_axi_arvalid = ar_pend;

  al_sync_fifo #(.WIDTH(DATA_WIDTH + 2), .DEPTH(MAX_OUT)) u_rfifo (
    .clk     (clk),
    .rst     (rst),
    .wr_en   (r_push),
    .wr_data (r_push_data),
    .rd_en   (m_al_rready),
    .rd_data (rfifo_q),
    .empty   (rfifo_empty),
    .count   (rcnt)
  );

  assign m_al_rvalid = !rfifo_empty;
  assign m_al_rresp  = rfifo_q[DATA_WIDTH+1:DATA_WIDTH];
  assign m_al_rdata  = rfifo_q[DATA_WIDTH-1:0];

endmodule
